// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: N-digit multiplexed seven-segment scanner with frame-synchronous double buffering,
// PWM dimming, leading-zero blanking and anode dead-time. Define SSD_BLINK_EN to add per-digit blink.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 100000,
  parameter int BRIGHT_BITS  = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   display_dig,
  input  logic [NUM_DIGITS-1:0]   point_dig,
`ifdef SSD_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_dig,
`endif
  input  logic                    load,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              segment,
  output logic                    frame_start,
  output logic                    load_pending
);
  localparam int DW_W  = $clog2(DWELL_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef SSD_BLINK_EN
  localparam int FW = 7 * NUM_DIGITS;
`else
  localparam int FW = 6 * NUM_DIGITS;
`endif
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [DW_W-1:0]        dwell_cnt_q, dwell_cnt_d;
  logic [IDX_W-1:0]       digit_idx_q, digit_idx_d;
  logic [BRIGHT_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]          shadow_q, shadow_d, active_q, active_d, frame_in;
  logic                   load_pending_q, load_pending_d;
  logic                   frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]  anode_q, anode_d;
  logic [7:0]             segment_q, segment_d;
  logic                   dwell_wrap, digit_on;
  logic [3:0]             act_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  act_disp, act_point, nib_live, lz_blank, blink_dark;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    hex7 = 7'h7F;
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  4'hF: hex7 = 7'b0001110;
    endcase
  endfunction

  // Buffered word layout, LSB first: nibbles, display enables, points, (blink enables).
`ifdef SSD_BLINK_EN
  assign frame_in = {blink_dig, point_dig, display_dig, data_in};
`else
  assign frame_in = {point_dig, display_dig, data_in};
`endif
  assign act_disp  = active_q[5*NUM_DIGITS-1:4*NUM_DIGITS];
  assign act_point = active_q[6*NUM_DIGITS-1:5*NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign act_nib[gi]  = active_q[4*gi +: 4];
      assign nib_live[gi] = (act_nib[gi] != 4'd0) || act_point[gi];
    end
  endgenerate

  // A digit is a leading zero when it and every more-significant digit are dead.
  always_comb begin
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_blank[i] = blank_lz && !(|(nib_live >> i));
    end
  end

  always_comb begin
    dwell_wrap    = (dwell_cnt_q == DWELL_LAST);
    dwell_cnt_d   = dwell_wrap ? '0 : dwell_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    if (dwell_wrap) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    end
    frame_start_d = dwell_wrap && (digit_idx_q == IDX_LAST);
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
  end

  // The frame_start cycle is the swap point; digit 0 is still in dead-time there.
  always_comb begin
    shadow_d       = load ? frame_in : shadow_q;
    active_d       = active_q;
    load_pending_d = load_pending_q;
    if (frame_start_q) begin
      load_pending_d = 1'b0;
      if (load) begin
        active_d = frame_in;
      end else if (load_pending_q) begin
        active_d = shadow_q;
      end
    end else if (load) begin
      load_pending_d = 1'b1;
    end
  end

`ifdef SSD_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start_q) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_dark = blink_phase_q ? active_q[7*NUM_DIGITS-1:6*NUM_DIGITS] : '0;
`else
  assign blink_dark = '0;
`endif

  always_comb begin
    digit_on  = act_disp[digit_idx_q] && !lz_blank[digit_idx_q] && !blink_dark[digit_idx_q]
                && (pwm_cnt_q <= brightness) && (dwell_cnt_q != '0);
    anode_d   = '1;
    segment_d = 8'hFF;
    if (digit_on) begin
      anode_d[digit_idx_q] = 1'b0;
      segment_d = {~act_point[digit_idx_q], hex7(act_nib[digit_idx_q])};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_cnt_q    <= '0;
      digit_idx_q    <= '0;
      pwm_cnt_q      <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      load_pending_q <= 1'b0;
      frame_start_q  <= 1'b0;
      anode_q        <= '1;
      segment_q      <= 8'hFF;
    end else begin
      dwell_cnt_q    <= dwell_cnt_d;
      digit_idx_q    <= digit_idx_d;
      pwm_cnt_q      <= pwm_cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      load_pending_q <= load_pending_d;
      frame_start_q  <= frame_start_d;
      anode_q        <= anode_d;
      segment_q      <= segment_d;
    end
  end

  assign anode        = anode_q;
  assign segment      = segment_q;
  assign frame_start  = frame_start_q;
  assign load_pending = load_pending_q;
endmodule
